// File: rtl/branch_unit.sv
// PC owner and branch resolver: latches ALU status flags, accepts one branch per
// two cycles through a valid/ready handshake and redirects or advances the PC.
module branch_unit #(
    parameter int n = 16,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   status_in,
    input  logic         load_s,
    input  logic         pc_inc,
    input  logic         br_valid,
    output logic         br_ready,
    input  logic [2:0]   br_op,
    input  logic [7:0]   imm8,
    input  logic [n-1:0] rd_in,
    output logic [n-1:0] pc,
    output logic [2:0]   flags,
    output logic         done,
    output logic         taken,
    output logic         link_we,
    output logic [n-1:0] link_val
);

    typedef enum logic {IDLE, RESOLVE} state_t;

    localparam logic [2:0] OP_B   = 3'b000;
    localparam logic [2:0] OP_BEQ = 3'b001;
    localparam logic [2:0] OP_BNE = 3'b010;
    localparam logic [2:0] OP_BLT = 3'b011;
    localparam logic [2:0] OP_BLE = 3'b100;
    localparam logic [2:0] OP_BL  = 3'b101;
    localparam logic [2:0] OP_BX  = 3'b110;
    localparam logic [2:0] OP_BLX = 3'b111;

    state_t                r_state;
    logic [2:0]            r_op;
    logic signed [7:0]     r_imm;
    logic [n-1:0]          r_rd;
    logic [n-1:0]          r_cap_pc;

    logic                  w_accept;
    logic                  w_cond;
    logic                  w_link;
    logic                  w_indirect;
    logic [n-1:0]          w_seq_pc;
    logic [n-1:0]          w_rel_pc;

    // Flags are {V,N,Z}; BLT/BLE use the signed-less-than form N^V.
    function automatic logic f_cond(input logic [2:0] op, input logic [2:0] f);
        logic lt;
        lt = f[1] ^ f[2];
        case (op)
            OP_BEQ:  f_cond = f[0];
            OP_BNE:  f_cond = ~f[0];
            OP_BLT:  f_cond = lt;
            OP_BLE:  f_cond = lt | f[0];
            default: f_cond = 1'b1;
        endcase
    endfunction

    function automatic logic [n-1:0] f_sext(input logic signed [7:0] imm);
        f_sext = {{(n-8){imm[7]}}, imm};
    endfunction

    assign br_ready   = (r_state == IDLE) && rst_n;
    assign w_accept   = br_valid && br_ready;
    assign w_cond     = f_cond(r_op, flags);
    assign w_link     = (r_op == OP_BL) || (r_op == OP_BLX);
    assign w_indirect = (r_op == OP_BX) || (r_op == OP_BLX);
    assign w_seq_pc   = r_cap_pc + n'(1);
    assign w_rel_pc   = w_seq_pc + f_sext(r_imm);

    // Branch operands are pure data and carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op     <= br_op;
            r_imm    <= imm8;
            r_rd     <= rd_in;
            r_cap_pc <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            pc       <= RESET_PC;
            flags    <= 3'b000;
            done     <= 1'b0;
            taken    <= 1'b0;
            link_we  <= 1'b0;
            link_val <= '0;
        end else begin
            if (load_s) begin
                flags <= status_in;
            end
            done     <= 1'b0;
            taken    <= 1'b0;
            link_we  <= 1'b0;
            link_val <= '0;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    r_state <= RESOLVE;
                end else if (pc_inc) begin
                    pc <= pc + n'(1);
                end
            end else begin
                // Flags read here predate any load_s in this cycle.
                if (w_indirect) begin
                    pc <= r_rd;
                end else if (w_cond) begin
                    pc <= w_rel_pc;
                end else begin
                    pc <= w_seq_pc;
                end
                done    <= 1'b1;
                taken   <= w_cond;
                link_we <= w_link;
                if (w_link) begin
                    link_val <= w_seq_pc;
                end
                r_state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit.
module tb_branch_unit;

    localparam int N = 16;
    localparam logic [2:0] B = 3'd0, BEQ = 3'd1, BNE = 3'd2, BLT = 3'd3;
    localparam logic [2:0] BLE = 3'd4, BL = 3'd5, BX = 3'd6, BLX = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   status_in;
    logic         load_s;
    logic         pc_inc;
    logic         br_valid;
    logic         br_ready;
    logic [2:0]   br_op;
    logic [7:0]   imm8;
    logic [N-1:0] rd_in;
    logic [N-1:0] pc;
    logic [2:0]   flags;
    logic         done;
    logic         taken;
    logic         link_we;
    logic [N-1:0] link_val;

    int checks = 0;
    int failures = 0;

    branch_unit #(.n(N), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .status_in(status_in), .load_s(load_s),
        .pc_inc(pc_inc), .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op),
        .imm8(imm8), .rd_in(rd_in), .pc(pc), .flags(flags), .done(done),
        .taken(taken), .link_we(link_we), .link_val(link_val)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one branch: accept edge, RESOLVE edge; returns in T+2.
    task automatic do_branch(input logic [2:0] op, input logic [7:0] imm, input logic [N-1:0] rd);
        br_valid = 1'b1; br_op = op; imm8 = imm; rd_in = rd;
        tick();
        br_valid = 1'b0;
        tick();
    endtask

    task automatic load_flags(input logic [2:0] f);
        load_s = 1'b1; status_in = f;
        tick();
        load_s = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_inc = 1'b1;
        tick(); tick();
        checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        checks++; if (flags !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", flags); end
        checks++; if (br_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", br_ready); end
        checks++; if (done !== 1'b0 || link_we !== 1'b0 || link_val !== 16'h0) begin
            failures++; $display("FAIL reset_outs got done=%b lwe=%b lval=%h exp 0/0/0000", done, link_we, link_val); end
        rst_n = 1'b1;
        tick(); tick(); tick();
        pc_inc = 1'b0;
        checks++; if (pc !== 16'h0003) begin failures++; $display("FAIL inc3 got=%h exp=0003", pc); end
        checks++; if (br_ready !== 1'b1) begin failures++; $display("FAIL ready_idle got=%b exp=1", br_ready); end
    endtask

    task automatic test_beq_load_on_accept();
        do_branch(BX, 8'h00, 16'h0010);
        br_valid = 1'b1; br_op = BEQ; imm8 = 8'h05; load_s = 1'b1; status_in = 3'b001;
        tick();
        br_valid = 1'b0; load_s = 1'b0;
        checks++; if (br_ready !== 1'b0) begin failures++; $display("FAIL resolve_ready got=%b exp=0", br_ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL early_done got=%b exp=0", done); end
        tick();
        checks++; if (done !== 1'b1 || taken !== 1'b1) begin
            failures++; $display("FAIL beq_taken got done=%b taken=%b exp 1/1", done, taken); end
        checks++; if (pc !== 16'h0016) begin failures++; $display("FAIL beq_pc got=%h exp=0016", pc); end
        checks++; if (br_ready !== 1'b1) begin failures++; $display("FAIL ready_back got=%b exp=1", br_ready); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", done); end

        do_branch(BX, 8'h00, 16'h0010);
        br_valid = 1'b1; br_op = BEQ; imm8 = 8'h05; load_s = 1'b1; status_in = 3'b000;
        tick();
        br_valid = 1'b0; load_s = 1'b0;
        tick();
        checks++; if (done !== 1'b1 || taken !== 1'b0) begin
            failures++; $display("FAIL beq_not got done=%b taken=%b exp 1/0", done, taken); end
        checks++; if (pc !== 16'h0011) begin failures++; $display("FAIL beq_not_pc got=%h exp=0011", pc); end
    endtask

    task automatic test_signed_wrap();
        load_flags(3'b100);
        do_branch(BX, 8'h00, 16'h0001);
        do_branch(BLT, 8'hFE, 16'h0000);
        checks++; if (taken !== 1'b1) begin failures++; $display("FAIL blt_v got=%b exp=1", taken); end
        checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL blt_pc got=%h exp=0000", pc); end
        do_branch(BX, 8'h00, 16'hFFFF);
        do_branch(B, 8'h00, 16'h0000);
        checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
    endtask

    task automatic test_link();
        do_branch(BX, 8'h00, 16'h0040);
        checks++; if (link_we !== 1'b0 || taken !== 1'b1) begin
            failures++; $display("FAIL bx_link got lwe=%b taken=%b exp 0/1", link_we, taken); end
        checks++; if (pc !== 16'h0040) begin failures++; $display("FAIL bx_pc got=%h exp=0040", pc); end
        do_branch(BLX, 8'h00, 16'h1234);
        checks++; if (pc !== 16'h1234) begin failures++; $display("FAIL blx_pc got=%h exp=1234", pc); end
        checks++; if (link_we !== 1'b1 || link_val !== 16'h0041) begin
            failures++; $display("FAIL blx_link got lwe=%b lval=%h exp 1/0041", link_we, link_val); end
        tick();
        checks++; if (link_we !== 1'b0) begin failures++; $display("FAIL link_pulse got=%b exp=0", link_we); end
    endtask

    typedef struct { logic [2:0] op; logic [2:0] f; logic exp_t; } cond_t;

    task automatic test_conditions();
        cond_t tbl[8];
        tbl[0] = '{BNE, 3'b001, 1'b0};
        tbl[1] = '{BNE, 3'b000, 1'b1};
        tbl[2] = '{BLT, 3'b010, 1'b1};
        tbl[3] = '{BLT, 3'b110, 1'b0};
        tbl[4] = '{BLE, 3'b001, 1'b1};
        tbl[5] = '{BLE, 3'b000, 1'b0};
        tbl[6] = '{BEQ, 3'b110, 1'b0};
        tbl[7] = '{BL,  3'b000, 1'b1};
        for (int i = 0; i < 8; i++) begin
            load_flags(tbl[i].f);
            do_branch(tbl[i].op, 8'h00, 16'h0000);
            checks++; if (taken !== tbl[i].exp_t || done !== 1'b1) begin
                failures++; $display("FAIL cond[%0d] got taken=%b done=%b exp %b/1", i, taken, done, tbl[i].exp_t); end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        do_branch(BX, 8'h00, 16'h1234);
        br_valid = 1'b1; br_op = B; imm8 = 8'h02; pc_inc = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_done = (k % 2 == 0);
            checks++; if (done !== exp_done || br_ready !== exp_done) begin
                failures++; $display("FAIL b2b[%0d] got done=%b ready=%b exp %b/%b", k, done, br_ready, exp_done, exp_done); end
        end
        br_valid = 1'b0;
        checks++; if (pc !== 16'h123D) begin failures++; $display("FAIL b2b_pc got=%h exp=123D", pc); end
        tick();
        pc_inc = 1'b0;
        checks++; if (pc !== 16'h123E) begin failures++; $display("FAIL post_inc got=%h exp=123E", pc); end
    endtask

    task automatic test_load_in_resolve();
        do_branch(BX, 8'h00, 16'h0100);
        load_flags(3'b000);
        br_valid = 1'b1; br_op = BEQ; imm8 = 8'h08;
        tick();
        br_valid = 1'b0; load_s = 1'b1; status_in = 3'b001;
        tick();
        load_s = 1'b0;
        checks++; if (taken !== 1'b0) begin failures++; $display("FAIL late_load_taken got=%b exp=0", taken); end
        checks++; if (pc !== 16'h0101) begin failures++; $display("FAIL late_load_pc got=%h exp=0101", pc); end
        checks++; if (flags !== 3'b001) begin failures++; $display("FAIL late_load_flags got=%b exp=001", flags); end
    endtask

    task automatic test_reset_mid_resolve();
        do_branch(BX, 8'h00, 16'h0200);
        br_valid = 1'b1; br_op = B; imm8 = 8'h10;
        tick();
        br_valid = 1'b0; rst_n = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", done); end
        checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL mid_rst_pc got=%h exp=0000", pc); end
        checks++; if (br_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", br_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (br_ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", br_ready); end
        do_branch(B, 8'h04, 16'h0000);
        checks++; if (done !== 1'b1 || pc !== 16'h0005) begin
            failures++; $display("FAIL after_rst got done=%b pc=%h exp 1/0005", done, pc); end
    endtask

    initial begin
        rst_n = 1'b0; status_in = 3'b000; load_s = 1'b0; pc_inc = 1'b0;
        br_valid = 1'b0; br_op = 3'b000; imm8 = 8'h00; rd_in = '0;
        #2;
        test_reset();
        test_beq_load_on_accept();
        test_signed_wrap();
        test_link();
        test_conditions();
        test_back_to_back();
        test_load_in_resolve();
        test_reset_mid_resolve();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
